fetch_unit: RTL and testbench

- Instruction-fetch stage of the RV32 core, directly upstream of the 64-word instruction ROM.
- Owns the program counter and drives the ROM word address.
- Captures the returned instruction word into the IF/ID pipeline register.
- Applies decode-stage stalls and execute-stage branch/jump redirects with flush.

---
 rtl/core_pkg.sv | 26 ++
 rtl/fetch_unit_if_id_reg.sv | 45 ++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32 front end.
//   XLEN            : architectural register / PC width
//   IMEM_AW_DEFAULT : default instruction ROM word-address width (64 words)
//   NOP_INST        : bubble encoding, ADDI x0,x0,0
//   if_id_t         : contents of the IF/ID pipeline register
//   word_align()    : clears the byte-offset bits of a byte address
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int          XLEN            = 32;
    localparam int          IMEM_AW_DEFAULT = 6;
    localparam logic [31:0] NOP_INST        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            valid;
    } if_id_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with hold and flush controls.
// Priority: reset > flush > hold > load.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-low reset
//   hold   : keep the current contents
//   flush  : load a bubble (pc taken from d, inst = NOP, valid = 0)
//   d      : next contents in normal operation
//   q      : current contents
// ---------------------------------------------------------------------------
module if_id_reg
    import core_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INST = core_pkg::NOP_INST
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg.pc    <= '0;
            q_reg.inst  <= BUBBLE_INST;
            q_reg.valid <= 1'b0;
        end else if (flush) begin
            // The flushed slot still records the PC it was fetched from.
            q_reg.pc    <= d.pc;
            q_reg.inst  <= BUBBLE_INST;
            q_reg.valid <= 1'b0;
        end else if (!hold) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// captures the returned word into IF/ID. Handles decode stalls and
// execute-stage redirects (which flush IF/ID).
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_cnt / flush_cnt.
// Ports:
//   clk, rst         : clock, synchronous active-low reset
//   stall            : hold PC and IF/ID
//   redirect         : taken branch/jump from EX this cycle
//   redirect_pc      : byte target of the redirect
//   imem_addr        : ROM word address (pc[IMEM_AW+1:2])
//   imem_data        : ROM read data (combinational from imem_addr)
//   pc               : current fetch PC
//   if_id_pc/inst/valid : IF/ID register contents
//   misalign         : one-cycle pulse, redirect target was not word aligned
//   oob              : current pc is outside the ROM range
//   fetch_cnt        : (optional) count of in-range normal advances
//   flush_cnt        : (optional) count of redirect cycles
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = core_pkg::IMEM_AW_DEFAULT,
    parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        pc,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_inst,
    output logic               if_id_valid,
    output logic               misalign,
    output logic               oob
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    import core_pkg::*;

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        misalign_reg;
    logic        oob_now;
    if_id_t      if_id_d;
    if_id_t      if_id_q;

    // Any set bit above the ROM byte-address range means the ROM address
    // would alias; such words must never reach decode as valid.
    assign oob_now   = |pc_reg[31:IMEM_AW+2];
    assign imem_addr = pc_reg[IMEM_AW+1:2];

    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = word_align(redirect_pc);
        end else if (!stall) begin
            pc_next = pc_reg + 32'd4;   // wraps naturally at 2^32
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg       <= RESET_PC;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            misalign_reg <= redirect & (|redirect_pc[1:0]);
        end
    end

    always_comb begin
        if_id_d.pc    = pc_reg;
        if_id_d.inst  = oob_now ? NOP_INST : imem_data;
        if_id_d.valid = ~oob_now;
    end

    if_id_reg #(
        .BUBBLE_INST (NOP_INST)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall),
        .flush (redirect),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign pc          = pc_reg;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_inst  = if_id_q.inst;
    assign if_id_valid = if_id_q.valid;
    assign misalign    = misalign_reg;
    assign oob         = oob_now;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (redirect) begin
            flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end else if (!stall && !oob_now) begin
            fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        misalign;
    logic        oob;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    logic [31:0] rom [64];
    assign imem_data = rom[imem_addr];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .pc          (pc),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst),
        .if_id_valid (if_id_valid),
        .misalign    (misalign),
        .oob         (oob)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] e_pc;
        logic [31:0] e_ifpc;
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_mis;
        logic        e_oob;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] romw(input int i);
        case (i)
            0: return 32'h0050_0093;
            1: return 32'h0050_0113;
            2: return 32'h0030_0193;
            default: return 32'hA000_0000 | i;
        endcase
    endfunction

    task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic [31:0] e_pc, input logic [31:0] e_ifpc, input logic [31:0] e_inst,
                       input logic e_valid, input logic e_mis, input logic e_oob);
        vec_t v;
        v.rst = r; v.stall = s; v.redirect = rd; v.rpc = rpc;
        v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_inst = e_inst;
        v.e_valid = e_valid; v.e_mis = e_mis; v.e_oob = e_oob;
        vecs.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                         input logic [31:0] e_inst, input logic e_valid, input logic e_mis,
                         input logic e_oob);
        logic [5:0] e_addr;
        e_addr = 6'((e_pc >> 2) % 64);
        n_vec++;
        if (pc !== e_pc || if_id_pc !== e_ifpc || if_id_inst !== e_inst || if_id_valid !== e_valid ||
            misalign !== e_mis || oob !== e_oob || imem_addr !== e_addr) begin
            n_bad++;
            $display("FAIL %s: got pc=%h ifpc=%h inst=%h v=%b mis=%b oob=%b addr=%0d, want pc=%h ifpc=%h inst=%h v=%b mis=%b oob=%b addr=%0d",
                     tag, pc, if_id_pc, if_id_inst, if_id_valid, misalign, oob, imem_addr,
                     e_pc, e_ifpc, e_inst, e_valid, e_mis, e_oob, e_addr);
        end else begin
            $display("ok   %s: pc=%h ifpc=%h inst=%h v=%b mis=%b oob=%b", tag, pc, if_id_pc,
                     if_id_inst, if_id_valid, misalign, oob);
        end
    endtask

    task automatic drive_cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    // Reference model state (spec-level: next PC and the slot that enters decode)
    logic [31:0] m_pc, m_ifpc, m_inst;
    logic        m_valid, m_mis;
    int unsigned m_fetch, m_flush;

    task automatic model_step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        if (!r) begin
            m_pc = 0; m_ifpc = 0; m_inst = NOP; m_valid = 0; m_mis = 0;
            m_fetch = 0; m_flush = 0;
        end else if (rd) begin
            m_ifpc = m_pc; m_inst = NOP; m_valid = 0;
            m_mis = (rpc % 4) != 0;
            m_pc = rpc - (rpc % 4);
            m_flush++;
        end else if (s) begin
            m_mis = 0;
        end else begin
            m_ifpc = m_pc;
            if (m_pc < 32'd256) begin
                m_inst = rom[m_pc / 4]; m_valid = 1; m_fetch++;
            end else begin
                m_inst = NOP; m_valid = 0;
            end
            m_pc = m_pc + 32'd4;
            m_mis = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = romw(i);
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        //   rst stall redir rpc            pc            ifpc          inst      v  mis oob
        add(0, 0, 0, 32'h0,          32'h0,        32'h0,        NOP,      0, 0, 0);
        add(0, 1, 1, 32'h44,         32'h0,        32'h0,        NOP,      0, 0, 0);
        add(1, 0, 0, 32'h0,          32'h4,        32'h0,        romw(0),  1, 0, 0);
        add(1, 0, 0, 32'h0,          32'h8,        32'h4,        romw(1),  1, 0, 0);
        add(1, 1, 0, 32'h0,          32'h8,        32'h4,        romw(1),  1, 0, 0);
        add(1, 1, 0, 32'h0,          32'h8,        32'h4,        romw(1),  1, 0, 0);
        add(1, 1, 0, 32'h0,          32'h8,        32'h4,        romw(1),  1, 0, 0);
        add(1, 0, 0, 32'h0,          32'hC,        32'h8,        romw(2),  1, 0, 0);
        add(1, 0, 0, 32'h0,          32'h10,       32'hC,        romw(3),  1, 0, 0);
        add(1, 0, 1, 32'h14,         32'h14,       32'h10,       NOP,      0, 0, 0);
        add(1, 0, 0, 32'h0,          32'h18,       32'h14,       romw(5),  1, 0, 0);
        add(1, 1, 1, 32'h22,         32'h20,       32'h18,       NOP,      0, 1, 0);
        add(1, 0, 0, 32'h0,          32'h24,       32'h20,       romw(8),  1, 0, 0);
        add(1, 0, 1, 32'h100,        32'h100,      32'h24,       NOP,      0, 0, 1);
        add(1, 0, 0, 32'h0,          32'h104,      32'h100,      NOP,      0, 0, 1);
        add(1, 0, 0, 32'h0,          32'h108,      32'h104,      NOP,      0, 0, 1);
        add(1, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h108,     NOP,      0, 0, 1);
        add(1, 0, 0, 32'h0,          32'h0,        32'hFFFF_FFFC, NOP,     0, 0, 0);
        add(1, 0, 0, 32'h0,          32'h4,        32'h0,        romw(0),  1, 0, 0);
        add(1, 0, 1, 32'h41,         32'h40,       32'h4,        NOP,      0, 1, 0);
        add(1, 0, 1, 32'h8,          32'h8,        32'h40,       NOP,      0, 0, 0);
        add(1, 0, 0, 32'h0,          32'hC,        32'h8,        romw(2),  1, 0, 0);
        add(0, 1, 0, 32'h0,          32'h0,        32'h0,        NOP,      0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifpc, vecs[i].e_inst,
                  vecs[i].e_valid, vecs[i].e_mis, vecs[i].e_oob);
        end

`ifdef FETCH_PERF_CNT_EN
        // Counter sequence from reset: 10 normal, 2 redirects, 3 stalls.
        for (int i = 0; i < 10; i++) drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 0, 1, 32'h0);
        drive_cycle(1, 1, 1, 32'h8);
        for (int i = 0; i < 3; i++) drive_cycle(1, 1, 0, 0);
        n_vec++;
        if (fetch_cnt !== 32'd10 || flush_cnt !== 32'd2) begin
            n_bad++;
            $display("FAIL perf_cnt: got fetch=%0d flush=%0d, want fetch=10 flush=2", fetch_cnt, flush_cnt);
        end else begin
            $display("ok   perf_cnt: fetch=%0d flush=%0d", fetch_cnt, flush_cnt);
        end
`endif

        // Randomized phase against the reference model, starting from reset.
        model_step(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        check("rnd_reset", m_pc, m_ifpc, m_inst, m_valid, m_mis, 1'b0);
        for (int i = 0; i < 400; i++) begin
            logic        r, s, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 63) != 0);
            s   = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 5))
                0:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       rpc = 32'($urandom_range(256, 300));
                default: rpc = 32'($urandom_range(0, 255));
            endcase
            model_step(r, s, rd, rpc);
            drive_cycle(r, s, rd, rpc);
            check($sformatf("rnd%0d", i), m_pc, m_ifpc, m_inst, m_valid, m_mis, m_pc >= 32'd256);
`ifdef FETCH_PERF_CNT_EN
            n_vec++;
            if (fetch_cnt !== m_fetch || flush_cnt !== m_flush) begin
                n_bad++;
                $display("FAIL rnd_cnt%0d: got fetch=%0d flush=%0d, want fetch=%0d flush=%0d",
                         i, fetch_cnt, flush_cnt, m_fetch, m_flush);
            end
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
